// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared definitions for the Y86-64 sequential controller:
//               instruction codes, processor status codes, sequencer state
//               encoding and the memory-instruction classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    // Instruction codes (icode field of the first instruction byte)
    localparam logic [3:0] c_ICODE_HALT  = 4'h0;
    localparam logic [3:0] c_ICODE_NOP   = 4'h1;
    localparam logic [3:0] c_ICODE_CMOV  = 4'h2;
    localparam logic [3:0] c_ICODE_IRMOV = 4'h3;
    localparam logic [3:0] c_ICODE_RMMOV = 4'h4;
    localparam logic [3:0] c_ICODE_MRMOV = 4'h5;
    localparam logic [3:0] c_ICODE_OP    = 4'h6;
    localparam logic [3:0] c_ICODE_JXX   = 4'h7;
    localparam logic [3:0] c_ICODE_CALL  = 4'h8;
    localparam logic [3:0] c_ICODE_RET   = 4'h9;
    localparam logic [3:0] c_ICODE_PUSH  = 4'hA;
    localparam logic [3:0] c_ICODE_POP   = 4'hB;

    // Processor status codes
    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    // Instructions that touch data memory and therefore visit MEMORY
    function automatic logic is_mem_icode(input logic [3:0] icode);
        return (icode == c_ICODE_RMMOV) || (icode == c_ICODE_MRMOV) ||
               (icode == c_ICODE_CALL)  || (icode == c_ICODE_RET)   ||
               (icode == c_ICODE_PUSH)  || (icode == c_ICODE_POP);
    endfunction

endpackage : y86_pkg
`default_nettype wire

// File: rtl/y86_pc_select.sv
`default_nettype none
// ============================================================================
// Module      : y86_pc_select
// Description : Combinational next-PC selection for the sequential Y86-64
//               datapath.
//   i_icode  : instruction code of the instruction being retired
//   i_cond   : branch condition from execute
//   i_valc   : constant word from fetch (jump / call target)
//   i_valp   : incremented PC from fetch (fall-through address)
//   i_valm   : memory read value (return address for ret)
//   o_next_pc: address of the next instruction
// Revision    : 1.0 - initial release
// ============================================================================
module y86_pc_select
    import y86_pkg::*;
(
    input  logic [3:0]  i_icode,
    input  logic        i_cond,
    input  logic [63:0] i_valc,
    input  logic [63:0] i_valp,
    input  logic [63:0] i_valm,
    output logic [63:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_valp;
        if (i_icode == c_ICODE_CALL) begin
            o_next_pc = i_valc;
        end else if ((i_icode == c_ICODE_JXX) && i_cond) begin
            o_next_pc = i_valc;
        end else if (i_icode == c_ICODE_RET) begin
            o_next_pc = i_valm;
        end
    end

endmodule : y86_pc_select
`default_nettype wire

// File: rtl/seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : seq_controller
// Description : Multi-cycle sequencer for the Y86-64 sequential datapath.
//               Owns the PC, steps one instruction through fetch, decode,
//               execute, memory and write-back (one stage per cycle), stalls
//               memory on a req/ack handshake, selects the next PC and keeps
//               the processor status.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : begin execution (only honoured in IDLE)
//   icode, cond         : instruction code / branch condition
//   instruct_err        : invalid instruction from fetch
//   mem_err             : fetch address error or data-memory error
//   valC, valP, valM    : constant word, incremented PC, memory read value
//   mem_ack             : data memory completed the access
//   PC                  : current instruction address
//   *_en                : one-hot stage strobes
//   mem_req             : data memory request, held until ack
//   stat, halted        : processor status, high while halted
//   cycle_count         : active (non-IDLE, non-HALT) cycles
//   instr_count         : retired instructions
// Revision    : 1.0 - initial release
// ============================================================================
module seq_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          CNT_W       = 32,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             cond,
    input  logic             instruct_err,
    input  logic             mem_err,
    input  logic [63:0]      valC,
    input  logic [63:0]      valP,
    input  logic [63:0]      valM,
    input  logic             mem_ack,
    output logic [63:0]      PC,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             mem_req,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [63:0]         r_pc;
    logic [2:0]          r_stat;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [CNT_W-1:0]    r_instr_count;
    logic [c_WAIT_W-1:0] r_wait;
    logic [c_WAIT_W-1:0] w_wait_next;
    logic [63:0]         r_valm;
    logic                r_fetch_en;
    logic                r_decode_en;
    logic                r_execute_en;
    logic                r_mem_en;
    logic                r_wb_en;
    logic                r_mem_req;
    logic                r_halted;
    logic                w_enter_halt;
    logic [2:0]          w_fault_stat;
    logic                w_capture_valm;
    logic [63:0]         w_next_pc;

    // valM is only guaranteed on the ack cycle, so ret uses the captured copy
    y86_pc_select u_pc_select (
        .i_icode   (icode),
        .i_cond    (cond),
        .i_valc    (valC),
        .i_valp    (valP),
        .i_valm    (r_valm),
        .o_next_pc (w_next_pc)
    );

    always_comb begin
        w_state_next   = r_state;
        w_enter_halt   = 1'b0;
        w_fault_stat   = r_stat;
        w_wait_next    = r_wait;
        w_capture_valm = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                // Fault priority: address error, then bad instruction, then halt
                if (mem_err) begin
                    w_state_next = S_HALT;
                    w_enter_halt = 1'b1;
                    w_fault_stat = c_STAT_ADR;
                end else if (instruct_err) begin
                    w_state_next = S_HALT;
                    w_enter_halt = 1'b1;
                    w_fault_stat = c_STAT_INS;
                end else if (icode == c_ICODE_HALT) begin
                    w_state_next = S_HALT;
                    w_enter_halt = 1'b1;
                    w_fault_stat = c_STAT_HLT;
                end else begin
                    w_state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                w_state_next = S_EXECUTE;
            end

            S_EXECUTE: begin
                // Wait counter is cleared here so it reads 0 on MEMORY entry
                w_wait_next = '0;
                if (is_mem_icode(icode)) begin
                    w_state_next = S_MEMORY;
                end else begin
                    w_state_next = S_WRITEBACK;
                end
            end

            S_MEMORY: begin
                // An ack on the final wait cycle still completes the access
                if (mem_ack) begin
                    if (mem_err) begin
                        w_state_next = S_HALT;
                        w_enter_halt = 1'b1;
                        w_fault_stat = c_STAT_ADR;
                    end else begin
                        w_state_next   = S_WRITEBACK;
                        w_capture_valm = 1'b1;
                    end
                end else if (r_wait == c_WAIT_LAST) begin
                    w_state_next = S_HALT;
                    w_enter_halt = 1'b1;
                    w_fault_stat = c_STAT_ADR;
                end else begin
                    w_wait_next = r_wait + c_WAIT_W'(1);
                end
            end

            S_WRITEBACK: begin
                w_state_next = S_PCUPD;
            end

            S_PCUPD: begin
                w_state_next = S_FETCH;
            end

            S_HALT: begin
                w_state_next = S_HALT;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_stat        <= c_STAT_AOK;
            r_cycle_count <= '0;
            r_instr_count <= '0;
            r_wait        <= '0;
            r_valm        <= '0;
            r_fetch_en    <= 1'b0;
            r_decode_en   <= 1'b0;
            r_execute_en  <= 1'b0;
            r_mem_en      <= 1'b0;
            r_wb_en       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;

            // Strobes are decoded from the next state so they coincide with it
            r_fetch_en   <= (w_state_next == S_FETCH);
            r_decode_en  <= (w_state_next == S_DECODE);
            r_execute_en <= (w_state_next == S_EXECUTE);
            r_mem_en     <= (w_state_next == S_MEMORY);
            r_wb_en      <= (w_state_next == S_WRITEBACK);
            r_mem_req    <= (w_state_next == S_MEMORY);
            r_halted     <= (w_state_next == S_HALT);

            if (w_capture_valm) begin
                r_valm <= valM;
            end

            if (w_enter_halt) begin
                r_stat <= w_fault_stat;
            end

            if (r_state == S_PCUPD) begin
                r_pc          <= w_next_pc;
                r_instr_count <= r_instr_count + CNT_W'(1);
            end

            if ((r_state != S_IDLE) && (r_state != S_HALT)) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

    assign PC          = r_pc;
    assign stat        = r_stat;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
    assign fetch_en    = r_fetch_en;
    assign decode_en   = r_decode_en;
    assign execute_en  = r_execute_en;
    assign mem_en      = r_mem_en;
    assign wb_en       = r_wb_en;
    assign mem_req     = r_mem_req;
    assign halted      = r_halted;

endmodule : seq_controller
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_controller
// Description : Self-checking bench for seq_controller. A reference model
//               walks each instruction through its stages and queues the
//               expected outputs per cycle; a monitor compares them against
//               the design on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_controller;

    localparam logic [63:0] c_RESET_PC    = 64'd64;
    localparam int          c_MEM_TIMEOUT = 16;

    localparam logic [4:0] c_EN_NONE = 5'b00000;
    localparam logic [4:0] c_EN_F    = 5'b10000;
    localparam logic [4:0] c_EN_D    = 5'b01000;
    localparam logic [4:0] c_EN_E    = 5'b00100;
    localparam logic [4:0] c_EN_M    = 5'b00010;
    localparam logic [4:0] c_EN_W    = 5'b00001;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  icode;
    logic        cond;
    logic        instruct_err;
    logic        mem_err;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        mem_ack;
    logic [63:0] PC;
    logic        fetch_en;
    logic        decode_en;
    logic        execute_en;
    logic        mem_en;
    logic        wb_en;
    logic        mem_req;
    logic [2:0]  stat;
    logic        halted;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;

    seq_controller #(
        .RESET_PC    (c_RESET_PC),
        .CNT_W       (32),
        .MEM_TIMEOUT (c_MEM_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .icode        (icode),
        .cond         (cond),
        .instruct_err (instruct_err),
        .mem_err      (mem_err),
        .valC         (valC),
        .valP         (valP),
        .valM         (valM),
        .mem_ack      (mem_ack),
        .PC           (PC),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .execute_en   (execute_en),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .mem_req      (mem_req),
        .stat         (stat),
        .halted       (halted),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  en;
        logic        req;
        logic        hlt;
        logic [63:0] pc;
        logic [2:0]  st;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    typedef struct {
        logic [3:0]  ic;
        logic        cnd;
        logic [63:0] vc;
        logic [63:0] vp;
        logic [63:0] vm;
        int          wait_n;   // memory cycle index carrying the ack
        logic        ierr;
        logic        ferr;     // fetch-time mem_err
        logic        merr;     // mem_err with the data ack
        int          rst_at;   // memory cycle index carrying reset, -1 none
    } ins_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model architectural state
    logic [63:0] m_pc;
    logic [2:0]  m_stat;
    logic [31:0] m_ic;
    logic [31:0] m_cc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Monitor: compares whatever the model queued for the current cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("stage_en",    {59'd0, fetch_en, decode_en, execute_en, mem_en, wb_en}, {59'd0, e.en});
            chk("mem_req",     {63'd0, mem_req}, {63'd0, e.req});
            chk("halted",      {63'd0, halted},  {63'd0, e.hlt});
            chk("PC",          PC, e.pc);
            chk("stat",        {61'd0, stat}, {61'd0, e.st});
            chk("instr_count", {32'd0, instr_count}, {32'd0, e.ic});
            chk("cycle_count", {32'd0, cycle_count}, {32'd0, e.cc});
        end
    end

    function automatic bit model_is_mem(input logic [3:0] ic);
        return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    endfunction

    function automatic logic [63:0] model_next_pc(input ins_t in);
        if (in.ic == 4'h8)                return in.vc;
        if ((in.ic == 4'h7) && in.cnd)    return in.vc;
        if (in.ic == 4'h9)                return in.vm;
        return in.vp;
    endfunction

    function automatic ins_t mk(input logic [3:0] ic, input logic cnd, input logic [63:0] vc,
                                input logic [63:0] vp, input logic [63:0] vm, input int wait_n);
        ins_t r;
        r.ic = ic; r.cnd = cnd; r.vc = vc; r.vp = vp; r.vm = vm; r.wait_n = wait_n;
        r.ierr = 1'b0; r.ferr = 1'b0; r.merr = 1'b0; r.rst_at = -1;
        return r;
    endfunction

    task automatic model_reset();
        m_pc = c_RESET_PC; m_stat = 3'd1; m_ic = 32'd0; m_cc = 32'd0;
    endtask

    // Queue the expected outputs for the current cycle and advance one cycle
    task automatic push_cycle(input logic [4:0] en, input logic req, input logic hlt, input bit active);
        exp_t e;
        e.en = en; e.req = req; e.hlt = hlt;
        e.pc = m_pc; e.st = m_stat; e.ic = m_ic; e.cc = m_cc;
        exp_q.push_back(e);
        @(posedge clk); #1;
        if (active) m_cc = m_cc + 32'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_err = 1'b0; instruct_err = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic start_run();
        start = 1'b1;
        push_cycle(c_EN_NONE, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            push_cycle(c_EN_NONE, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // HALT must hold still even when start is pulsed
    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'($urandom_range(0, 1));
            push_cycle(c_EN_NONE, 1'b0, 1'b1, 1'b0);
        end
        start = 1'b0;
    endtask

    task automatic exec_instr(input ins_t in, output bit stop);
        bit acked;
        stop  = 1'b0;
        acked = 1'b0;
        icode = in.ic; cond = in.cnd; valC = in.vc; valP = in.vp; valM = in.vm;
        instruct_err = in.ierr; mem_err = in.ferr; mem_ack = 1'b0;
        push_cycle(c_EN_F, 1'b0, 1'b0, 1'b1);
        instruct_err = 1'b0; mem_err = 1'b0;
        if (in.ferr)       begin m_stat = 3'd3; stop = 1'b1; return; end
        if (in.ierr)       begin m_stat = 3'd4; stop = 1'b1; return; end
        if (in.ic == 4'h0) begin m_stat = 3'd2; stop = 1'b1; return; end
        push_cycle(c_EN_D, 1'b0, 1'b0, 1'b1);
        push_cycle(c_EN_E, 1'b0, 1'b0, 1'b1);
        if (model_is_mem(in.ic)) begin
            for (int w = 0; w < c_MEM_TIMEOUT; w++) begin
                mem_ack = (w == in.wait_n);
                mem_err = (w == in.wait_n) && in.merr;
                reset   = (w == in.rst_at);
                push_cycle(c_EN_M, 1'b1, 1'b0, 1'b1);
                mem_ack = 1'b0;
                mem_err = 1'b0;
                if (w == in.rst_at) begin
                    reset = 1'b0;
                    model_reset();
                    stop = 1'b1;
                    return;
                end
                if (w == in.wait_n) begin
                    // valM is only valid with the ack; scramble it afterwards
                    valM = {$urandom, $urandom};
                    if (in.merr) begin m_stat = 3'd3; stop = 1'b1; return; end
                    acked = 1'b1;
                    break;
                end
            end
            if (!acked) begin m_stat = 3'd3; stop = 1'b1; return; end
        end
        push_cycle(c_EN_W, 1'b0, 1'b0, 1'b1);
        push_cycle(c_EN_NONE, 1'b0, 1'b0, 1'b1);
        m_pc = model_next_pc(in);
        m_ic = m_ic + 32'd1;
    endtask

    function automatic ins_t rand_instr();
        ins_t r;
        r = mk(4'($urandom_range(1, 11)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 6));
        return r;
    endfunction

    initial begin
        bit   stop;
        ins_t in;
        reset = 1'b1; start = 1'b0; icode = 4'h1; cond = 1'b0; instruct_err = 1'b0;
        mem_err = 1'b0; valC = '0; valP = '0; valM = '0; mem_ack = 1'b0;
        @(posedge clk); #1;
        do_reset();
        idle_cycles(2);

        // Directed program: cmov, taken/not-taken jxx, mrmov, ret, call, nop, halt
        start_run();
        exec_instr(mk(4'h2, 1'b0, 64'h0,   64'd66,  64'h0,     0), stop);
        exec_instr(mk(4'h7, 1'b1, 64'h34,  64'd69,  64'h0,     0), stop);
        exec_instr(mk(4'h7, 1'b0, 64'h34,  64'd69,  64'h0,     0), stop);
        exec_instr(mk(4'h5, 1'b0, 64'h0,   64'h50,  64'hdead,  3), stop);
        exec_instr(mk(4'h9, 1'b0, 64'h0,   64'h58,  64'h100,   0), stop);
        exec_instr(mk(4'h8, 1'b0, 64'h200, 64'h109, 64'h0,     1), stop);
        exec_instr(mk(4'h1, 1'b0, 64'h0,   64'd68,  64'h0,     0), stop);
        exec_instr(mk(4'h0, 1'b0, 64'h0,   64'd69,  64'h0,     0), stop);
        halt_cycles(4);

        // Invalid instruction
        do_reset();
        start_run();
        in = mk(4'h6, 1'b0, 64'h0, 64'h42, 64'h0, 0); in.ierr = 1'b1;
        exec_instr(in, stop);
        halt_cycles(3);

        // Address error outranks invalid instruction
        do_reset();
        start_run();
        in = mk(4'h6, 1'b0, 64'h0, 64'h42, 64'h0, 0); in.ierr = 1'b1; in.ferr = 1'b1;
        exec_instr(in, stop);
        halt_cycles(3);

        // Memory never acknowledges
        do_reset();
        start_run();
        exec_instr(mk(4'h1, 1'b0, 64'h0, 64'h80, 64'h0, 0), stop);
        exec_instr(mk(4'h5, 1'b0, 64'h0, 64'h8a, 64'h0, 99), stop);
        halt_cycles(3);

        // Data-memory error with the ack
        do_reset();
        start_run();
        in = mk(4'hA, 1'b0, 64'h0, 64'h42, 64'h0, 2); in.merr = 1'b1;
        exec_instr(in, stop);
        halt_cycles(3);

        // Reset in the middle of a memory wait, then resume normally
        do_reset();
        start_run();
        in = mk(4'hA, 1'b0, 64'h0, 64'h42, 64'h0, 5); in.rst_at = 2;
        exec_instr(in, stop);
        idle_cycles(2);
        start_run();
        exec_instr(mk(4'h3, 1'b0, 64'h0, 64'h4a, 64'h0, 0), stop);
        exec_instr(mk(4'hB, 1'b0, 64'h0, 64'h4c, 64'h0, 15), stop);
        exec_instr(mk(4'h0, 1'b0, 64'h0, 64'h4d, 64'h0, 0), stop);
        halt_cycles(2);

        // Randomized programs, each ending in a halt or fault
        for (int r = 0; r < 25; r++) begin
            int n;
            do_reset();
            idle_cycles($urandom_range(0, 2));
            start_run();
            n = $urandom_range(3, 12);
            stop = 1'b0;
            for (int i = 0; i < n && !stop; i++) begin
                exec_instr(rand_instr(), stop);
            end
            if (!stop) begin
                in = rand_instr();
                case ($urandom_range(0, 4))
                    0: in.ic = 4'h0;
                    1: in.ierr = 1'b1;
                    2: in.ferr = 1'b1;
                    3: begin in.ic = 4'h5; in.merr = 1'b1; end
                    default: begin in.ic = 4'hB; in.wait_n = 100; end
                endcase
                exec_instr(in, stop);
            end
            halt_cycles(3);
        end

        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_seq_controller
`default_nettype wire
